// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter and sequencer for a shared 4:1 data mux.
// Grants one requester at a time, drives the mux select and forwards the granted
// input to a valid/ready port. Each grant is capped at MAX_BEATS transfers, and
// every release is followed by one idle cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[3:0]          per-requester request, held until served
//   i0..i3            requester data inputs
//   out_ready         downstream accepts a beat this cycle
//   gnt[3:0]          one-hot grant (registered), zero when idle
//   select[1:0]       mux select (registered), index of the granted requester
//   out               selected data, zero when nothing is granted
//   out_valid         a grant is active and its requester still asserts req
module rr_mux_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    select_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    win;
  logic          beat;

  // Winner search: scan downward so the requester closest to ptr wins last.
  always_comb begin
    win = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
  end

  assign out_valid = (gnt != 4'd0) && req[select];
  assign beat      = out_valid && out_ready;

  // Combinational data mux, forced to zero while idle.
  always_comb begin
    out = '0;
    if (gnt != 4'd0) begin
      case (select)
        2'd0: out = i0;
        2'd1: out = i1;
        2'd2: out = i2;
        2'd3: out = i3;
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    select_nxt = select;
    ptr_nxt    = ptr;
    count_nxt  = count;
    case (state)
      IDLE: begin
        if (req != 4'd0) begin
          state_nxt  = GRANT;
          select_nxt = win;
          gnt_nxt    = 4'(1) << win;
          count_nxt  = '0;
        end
      end
      GRANT: begin
        // A withdrawn request and a final beat in the same cycle release once.
        if (!req[select] || (beat && count == LAST_BEAT)) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'd0;
          count_nxt = '0;
          ptr_nxt   = select + 2'd1;
        end else if (beat) begin
          count_nxt = count + CW'(1);
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= 4'd0;
      select <= 2'd0;
      ptr    <= 2'd0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      select <= select_nxt;
      ptr    <= ptr_nxt;
      count  <= count_nxt;
    end
  end

endmodule
